// File: rtl/collatz_pkg.sv
// Shared definitions for the multi-lane Collatz search engine.
//   ALARM_*      : encodings reported on alarm_cause
//   lane_state_e : per-lane engine state
package collatz_pkg;

    localparam logic [1:0] ALARM_NONE     = 2'd0;
    localparam logic [1:0] ALARM_OVERFLOW = 2'd1;
    localparam logic [1:0] ALARM_STEPLIM  = 2'd2;
    localparam logic [1:0] ALARM_EXHAUST  = 2'd3;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } lane_state_e;

endpackage

// File: rtl/collatz_lane.sv
// One Collatz step engine. It holds the candidate (start), the current
// trajectory value (actual) and the step count. It performs one update per
// clken cycle and reports retire/alarm combinationally so the top level can
// act on the same edge.
//
// Ports:
//   clk, resetn      : clock, synchronous active-low reset
//   clken            : advance enable
//   clear            : synchronous clear (search restart)
//   freeze           : global alarm; holds the lane still
//   grant/grant_value: start a new candidate (only honoured when IDLE)
//   idle             : lane is IDLE
//   retire           : trajectory dropped below start this cycle
//   ovf / steplim    : arithmetic overflow / step-limit hit this cycle
//   start            : candidate currently held
//   steps_next       : step count after this cycle's update
//
// state | meaning
// ------+-----------------------------------------------
// IDLE  | no candidate, waiting for a grant
// RUN   | iterating the candidate until it drops below start
module collatz_lane
    import collatz_pkg::*;
#(
    parameter int          bits       = 160,
    parameter int          step_bits  = 16,
    parameter int unsigned step_limit = 16'd60000
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 clken,
    input  logic                 clear,
    input  logic                 freeze,
    input  logic                 grant,
    input  logic [bits-1:0]      grant_value,
    output logic                 idle,
    output logic                 retire,
    output logic                 ovf,
    output logic                 steplim,
    output logic [bits-1:0]      start,
    output logic [step_bits-1:0] steps_next
);

    localparam logic [step_bits-1:0] LIMIT = step_bits'(step_limit);

    lane_state_e          state_q, state_d;
    logic [bits-1:0]      start_q, start_d;
    logic [bits-1:0]      actual_q, actual_d, actual_nx;
    logic [step_bits-1:0] steps_q, steps_d, steps_nx;
    logic [bits:0]        half_t;
    logic                 odd_ovf;

    always_comb begin
        // For odd x, (3x+1)/2 == x + (x>>1) + 1. 3x+1 reaching 2**bits is the
        // same as this half value reaching 2**(bits-1).
        half_t  = {1'b0, actual_q} + {2'b00, actual_q[bits-1:1]} + (bits+1)'(1);
        odd_ovf = |half_t[bits:bits-1];
        if (actual_q[0]) begin
            actual_nx = half_t[bits-1:0];
            steps_nx  = steps_q + step_bits'(2);
        end else begin
            actual_nx = {1'b0, actual_q[bits-1:1]};
            steps_nx  = steps_q + step_bits'(1);
        end

        state_d  = state_q;
        start_d  = start_q;
        actual_d = actual_q;
        steps_d  = steps_q;
        retire   = 1'b0;
        ovf      = 1'b0;
        steplim  = 1'b0;

        if (clken && !freeze) begin
            case (state_q)
                IDLE: begin
                    if (grant) begin
                        state_d  = RUN;
                        start_d  = grant_value;
                        actual_d = grant_value;
                        steps_d  = '0;
                    end
                end
                RUN: begin
                    if (actual_q[0] && odd_ovf) begin
                        ovf = 1'b1;
                    end else begin
                        actual_d = actual_nx;
                        steps_d  = steps_nx;
                        if (actual_nx < start_q) begin
                            retire  = 1'b1;
                            state_d = IDLE;
                        end else if (steps_nx >= LIMIT) begin
                            steplim = 1'b1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn || clear) begin
            state_q  <= IDLE;
            start_q  <= '0;
            actual_q <= '0;
            steps_q  <= '0;
        end else begin
            state_q  <= state_d;
            start_q  <= start_d;
            actual_q <= actual_d;
            steps_q  <= steps_d;
        end
    end

    assign idle       = (state_q == IDLE);
    assign start      = start_q;
    assign steps_next = steps_nx;

endmodule

// File: rtl/collatz_search.sv
// Multi-lane Collatz search engine. A shared candidate counter feeds `lanes`
// step engines; the top tracks verified count, record stopping time and a
// sticky alarm (overflow, step limit, candidate exhaustion).
//
// Build option: COLLATZ_SEARCH_SIEVE_EN restricts candidates to 3 mod 4
// (step 4, load forces load_value|3). Default: odd candidates, step 2.
//
// Ports:
//   clk, resetn            : clock, synchronous active-low reset
//   clken                  : advance enable (load acts regardless)
//   load / load_value      : restart search at load_value
//   halt                   : stop issuing candidates, let lanes drain
//   running                : any lane busy
//   next_start             : next candidate to issue
//   checked                : number of retired candidates
//   record_start/steps     : longest stopping time seen and its candidate
//   alarm/alarm_cause/start: sticky alarm, its cause and culprit candidate
module collatz_search
    import collatz_pkg::*;
#(
    parameter int          bits       = 160,
    parameter int          lanes      = 4,
    parameter int          step_bits  = 16,
    parameter int unsigned step_limit = 16'd60000
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 clken,
    input  logic                 load,
    input  logic [bits-1:0]      load_value,
    input  logic                 halt,
    output logic                 running,
    output logic [bits-1:0]      next_start,
    output logic [63:0]          checked,
    output logic [bits-1:0]      record_start,
    output logic [step_bits-1:0] record_steps,
    output logic                 alarm,
    output logic [1:0]           alarm_cause,
    output logic [bits-1:0]      alarm_start
);

`ifdef COLLATZ_SEARCH_SIEVE_EN
    localparam logic [bits:0] INC = (bits+1)'(4);
`else
    localparam logic [bits:0] INC = (bits+1)'(2);
`endif

    logic [bits-1:0]      next_start_q, next_start_d;
    logic [63:0]          checked_q, checked_d;
    logic [bits-1:0]      record_start_q, record_start_d;
    logic [step_bits-1:0] record_steps_q, record_steps_d;
    logic                 alarm_q, alarm_d;
    logic [1:0]           cause_q, cause_d;
    logic [bits-1:0]      astart_q, astart_d;

    logic [lanes-1:0]     idle_vec, retire_vec, ovf_vec, stp_vec, grant_vec;
    logic [bits-1:0]      lane_start [lanes];
    logic [step_bits-1:0] lane_steps [lanes];

    logic [bits-1:0]      load_start;
    logic [bits:0]        inc_sum;
    logic                 exhaust, found_idle, best_found, lane_hit;
    logic [4:0]           n_retire;
    logic [step_bits-1:0] best_steps;
    logic [bits-1:0]      best_start;

    for (genvar i = 0; i < lanes; i++) begin : g_lane
        collatz_lane #(
            .bits       (bits),
            .step_bits  (step_bits),
            .step_limit (step_limit)
        ) u_lane (
            .clk         (clk),
            .resetn      (resetn),
            .clken       (clken),
            .clear       (load),
            .freeze      (alarm_q),
            .grant       (grant_vec[i]),
            .grant_value (next_start_q),
            .idle        (idle_vec[i]),
            .retire      (retire_vec[i]),
            .ovf         (ovf_vec[i]),
            .steplim     (stp_vec[i]),
            .start       (lane_start[i]),
            .steps_next  (lane_steps[i])
        );
    end

    always_comb begin
`ifdef COLLATZ_SEARCH_SIEVE_EN
        load_start = load_value | bits'(3);
`else
        load_start = load_value | bits'(1);
        if (load_start < bits'(3)) load_start = bits'(3);
`endif
    end

    // Grant: lowest-index idle lane; a counter carry means the space is used up.
    always_comb begin
        inc_sum      = {1'b0, next_start_q} + INC;
        grant_vec    = '0;
        next_start_d = next_start_q;
        exhaust      = 1'b0;
        found_idle   = 1'b0;
        if (clken && !halt && !alarm_q) begin
            for (int i = 0; i < lanes; i++) begin
                if (!found_idle && idle_vec[i]) begin
                    found_idle = 1'b1;
                    if (inc_sum[bits]) begin
                        exhaust = 1'b1;
                    end else begin
                        grant_vec[i] = 1'b1;
                        next_start_d = inc_sum[bits-1:0];
                    end
                end
            end
        end
    end

    // Retire accounting: strict '>' in index order keeps the lowest index on ties.
    always_comb begin
        n_retire   = '0;
        best_found = 1'b0;
        best_steps = '0;
        best_start = '0;
        for (int i = 0; i < lanes; i++) begin
            if (retire_vec[i]) begin
                n_retire = n_retire + 5'd1;
                if (!best_found || lane_steps[i] > best_steps) begin
                    best_found = 1'b1;
                    best_steps = lane_steps[i];
                    best_start = lane_start[i];
                end
            end
        end
        checked_d      = checked_q + 64'(n_retire);
        record_start_d = record_start_q;
        record_steps_d = record_steps_q;
        if (best_found && best_steps > record_steps_q) begin
            record_start_d = best_start;
            record_steps_d = best_steps;
        end
    end

    // Lane alarms outrank exhaustion; lowest lane index wins among lanes.
    always_comb begin
        alarm_d  = alarm_q;
        cause_d  = cause_q;
        astart_d = astart_q;
        lane_hit = 1'b0;
        if (!alarm_q) begin
            for (int i = 0; i < lanes; i++) begin
                if (!lane_hit && (ovf_vec[i] || stp_vec[i])) begin
                    lane_hit = 1'b1;
                    alarm_d  = 1'b1;
                    cause_d  = ovf_vec[i] ? ALARM_OVERFLOW : ALARM_STEPLIM;
                    astart_d = lane_start[i];
                end
            end
            if (!lane_hit && exhaust) begin
                alarm_d  = 1'b1;
                cause_d  = ALARM_EXHAUST;
                astart_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn || load) begin
            next_start_q   <= resetn ? load_start : bits'(3);
            checked_q      <= '0;
            record_start_q <= '0;
            record_steps_q <= '0;
            alarm_q        <= 1'b0;
            cause_q        <= ALARM_NONE;
            astart_q       <= '0;
        end else begin
            next_start_q   <= next_start_d;
            checked_q      <= checked_d;
            record_start_q <= record_start_d;
            record_steps_q <= record_steps_d;
            alarm_q        <= alarm_d;
            cause_q        <= cause_d;
            astart_q       <= astart_d;
        end
    end

    assign running      = ~&idle_vec;
    assign next_start   = next_start_q;
    assign checked      = checked_q;
    assign record_start = record_start_q;
    assign record_steps = record_steps_q;
    assign alarm        = alarm_q;
    assign alarm_cause  = cause_q;
    assign alarm_start  = astart_q;

endmodule
